seven_seg_scan_cntrl: RTL and testbench
=======================================

SEVEN_SEG_SCAN_CNTRL -- requirements
Module: seven_seg_scan_cntrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Parameter NUM_DIGITS, default 4, SHALL set the digit count (legal range 1..8).
REQ-003 Parameter REFRESH_DIV, default 100000, SHALL set the clk cycles each digit is held (legal range >= 2).
REQ-004 Parameter ACTIVE_LOW, default 1, SHALL set polarity: 1 means 0 = segment lit / anode enabled.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
REQ-008 load  input  1  when high at a rising edge, value SHALL be captured into the internal shadow register.
REQ-009 blank_mask  input  NUM_DIGITS  bit i high forces digit i dark.
REQ-010 seg  output  7  segments, seg[0]=a ... seg[6]=g, registered.
REQ-011 an  output  NUM_DIGITS  one-hot digit enables, registered.

Function
REQ-012 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; terminal count is prescaler == REFRESH_DIV-1.
REQ-013 On terminal count, digit index SHALL increment, wrapping NUM_DIGITS-1 -> 0; otherwise it holds.
REQ-014 seg and an SHALL be registered every cycle from the current shadow, index and blank_mask (1-cycle output latency).
REQ-015 With load high at edge N, the new value SHALL appear on seg no later than edge N+1 for the selected digit.
REQ-016 load held high SHALL capture on every edge; load low SHALL hold the shadow.
REQ-017 Decode SHALL cover all 16 nibbles, 0-9 and A,b,C,d,E,F, standard a-g patterns (e.g. 0 -> a..f lit, g dark; 8 -> all lit).
REQ-018 Exactly one an bit SHALL be active when the selected digit is displayed; a blanked digit SHALL drive all an inactive and all seg dark.
REQ-019 blank_mask SHALL be sampled combinationally into the output register, no capture on load.
REQ-020 NUM_DIGITS = 1 SHALL keep index at 0 permanently with an[0] active unless blanked.
REQ-021 Simultaneous load and terminal count SHALL show the new shadow on the newly selected digit one cycle later.

Reset
REQ-022 Reset SHALL clear prescaler to 0, index to 0 and shadow to 0.
REQ-023 During reset seg SHALL be all dark and an all inactive (polarity per ACTIVE_LOW).
REQ-024 Reset asserted mid-scan SHALL take effect immediately; after release, the first output edge SHALL select digit 0 showing "0".

Configuration
REQ-025 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN defined: digit i (i > 0) SHALL be dark when shadow nibbles NUM_DIGITS-1 down to i are all zero; digit 0 never suppressed.
REQ-026 Macro undefined: all digits SHALL display per shadow and blank_mask only; no suppression logic present.

Structure
REQ-027 A shared package seven_seg_pkg SHALL hold the 16-entry segment-pattern constants and the SEG_OFF constant.
REQ-028 Hex-to-segment decode SHALL be a combinational sub-module seven_seg_hex_decode, instanced once on the selected nibble.
REQ-029 Polarity inversion SHALL be applied only at the output register.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-030 Reset held, then released -> seg=7'b1111111, an=4'b1111 during reset; first post-release output an=4'b1110, seg=7'b1000000.
REQ-031 load with value=16'h1234 -> an cycles 1110,1101,1011,0111 each for 4 clks, seg shows 4,3,2,1, wrap back to 1110.
REQ-032 value=16'hABCD loaded, blank_mask=4'b0100 -> digit 2 slot gives an=4'b1111, seg=7'b1111111; others show D,C,A.
REQ-033 load asserted on terminal-count cycle with value change 16'h0000 -> 16'h00F0 -> next digit (1) shows F one cycle later.
REQ-034 Macro defined, value=16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0; macro undefined -> all four lit.
REQ-035 Reset pulsed while index=2 -> outputs dark immediately; scanning restarts at digit 0 with shadow 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment patterns and blanking constant for the seven-segment scanner
package seven_seg_pkg;

    // Active-high internal encoding, bit 0 = a ... bit 6 = g; entry 15 (F) listed first.
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_PATTERNS[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// rtl/seven_seg_hex_decode.sv - combinational hex nibble to active-high a..g segment decode
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_scan_cntrl.sv
// rtl/seven_seg_scan_cntrl.sv - multiplexed seven-segment scan controller with registered outputs
// Optional leading-zero suppression: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_cntrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]        prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    terminal;
    logic [3:0]              sel_nibble;
    logic                    sel_masked;
    logic                    lz_dark;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_act;
    logic [NUM_DIGITS-1:0]   an_act;

    always_comb begin
        terminal    = (prescaler_q == PRE_LAST);
        prescaler_d = terminal ? '0 : prescaler_q + 1'b1;
        idx_d       = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        shadow_d = load ? value : shadow_q;
    end

    always_comb begin
        sel_nibble = 4'h0;
        sel_masked = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nibble = shadow_q[4*i +: 4];
                sel_masked = blank_mask[i];
            end
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic upper_nz;

    // Digit i is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) >= idx_q && shadow_q[4*i +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        lz_dark = (idx_q != '0) && !upper_nz;
    end
`else
    always_comb begin
        lz_dark = 1'b0;
    end
`endif

    seven_seg_hex_decode u_decode (
        .nibble (sel_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        an_act  = '0;
        seg_act = SEG_OFF;
        if (!sel_masked && !lz_dark) begin
            seg_act = dec_seg;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_act[i] = 1'b1;
                end
            end
        end
        // Everything upstream is active-high; polarity flips only on entry to the output flops.
        seg_d = seg_act ^ SEG_POL;
        an_d  = an_act ^ AN_POL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            seg_q       <= SEG_OFF ^ SEG_POL;
            an_q        <= AN_POL;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan_cntrl.sv
// tb/tb_seven_seg_scan_cntrl.sv - scoreboard bench for seven_seg_scan_cntrl (4 digits, divide-by-4, active-low)
module tb_seven_seg_scan_cntrl;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  blank_mask;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seven_seg_scan_cntrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .blank_mask (blank_mask),
        .seg        (seg),
        .an         (an)
    );

    // Active-low a..g codes (bit 0 = a).
    function automatic logic [6:0] exp_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg) begin
                errors++;
                $display("FAIL scoreboard[%0d] an=%b seg=%b expected an=%b seg=%b", pops, an, seg, e.an, e.seg);
            end
            pops++;
        end
    end

    task automatic push_digit(input int d, input logic [3:0] nib, input int n);
        exp_t e;
        logic [3:0] one;
        one   = 4'b0001;
        e.an  = ~(one << d);
        e.seg = exp_seg(nib);
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s drain timeout: %0d entries left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Leaves the bench 2 time units after the first post-release edge; value is then scrambled.
    task automatic start_scan(input logic [15:0] v, input logic do_load);
        reset = 1'b1;
        value = v;
        load  = do_load;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        load  = 1'b0;
        value = 16'hFFFF;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (seg !== 7'b1111111 || an !== 4'b1111) begin
            errors++;
            $display("FAIL reset_hold seg=%b an=%b expected seg=1111111 an=1111", seg, an);
        end
        start_scan(16'h0000, 1'b0);
        push_digit(0, 4'h0, 4);
        wait_drain("reset_release");
    endtask

    task automatic test_scan;
        start_scan(16'h1234, 1'b1);
        push_digit(0, 4'h0, 1);
        push_digit(0, 4'h4, 3);
        push_digit(1, 4'h3, 4);
        push_digit(2, 4'h2, 4);
        push_digit(3, 4'h1, 4);
        push_digit(0, 4'h4, 4);
        wait_drain("scan");
    endtask

    task automatic test_blank;
        blank_mask = 4'b0100;
        start_scan(16'hABCD, 1'b1);
        push_digit(0, 4'h0, 1);
        push_digit(0, 4'hD, 3);
        push_digit(1, 4'hC, 4);
        push_dark(4);
        push_digit(3, 4'hA, 4);
        wait_drain("blank");
        blank_mask = 4'b0000;
    endtask

    task automatic test_leading_zero;
        start_scan(16'h0050, 1'b1);
        push_digit(0, 4'h0, 4);
        push_digit(1, 4'h5, 4);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        push_dark(8);
`else
        push_digit(2, 4'h0, 4);
        push_digit(3, 4'h0, 4);
`endif
        wait_drain("leading_zero");
    endtask

    task automatic test_load_at_terminal;
        start_scan(16'h0000, 1'b0);
        value = 16'h00F0;
        push_digit(0, 4'h0, 4);
        push_digit(1, 4'hF, 4);
        repeat (2) @(posedge clk);
        #2;
        load = 1'b1;
        @(posedge clk);
        #2;
        load = 1'b0;
        wait_drain("load_at_terminal");
    endtask

    task automatic test_reset_mid_scan;
        start_scan(16'h1234, 1'b1);
        push_digit(0, 4'h0, 1);
        push_digit(0, 4'h4, 3);
        push_digit(1, 4'h3, 4);
        push_digit(2, 4'h2, 1);
        wait_drain("pre_reset");
        reset = 1'b1;
        #1;
        checks++;
        if (seg !== 7'b1111111 || an !== 4'b1111) begin
            errors++;
            $display("FAIL async_reset seg=%b an=%b expected seg=1111111 an=1111", seg, an);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        push_digit(0, 4'h0, 4);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        push_dark(1);
`else
        push_digit(1, 4'h0, 1);
`endif
        wait_drain("post_reset");
    endtask

    initial begin
        reset      = 1'b1;
        value      = 16'h0000;
        load       = 1'b0;
        blank_mask = 4'b0000;
        test_reset();
        test_scan();
        test_blank();
        test_leading_zero();
        test_load_at_terminal();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at %0t, expected completion earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
